// File: rtl/lock_sequencer_pkg.sv
// ============================================================================
// Module      : lock_sequencer_pkg
// Description : State encoding and default parameters shared by the lock
//               sequencer and its lockout timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lock_sequencer_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_GET_PASS = 3'd1;
    localparam logic [STATE_W-1:0] ST_CHECK    = 3'd2;
    localparam logic [STATE_W-1:0] ST_LOAD_L   = 3'd3;
    localparam logic [STATE_W-1:0] ST_LOAD_R   = 3'd4;
    localparam logic [STATE_W-1:0] ST_LOCKOUT  = 3'd5;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_LOCK_CYCLES = 16;

endpackage

`default_nettype wire

// File: rtl/lock_sequencer_timer.sv
// ============================================================================
// Module      : lock_timer
// Description : Loadable up-counter with a terminal-count flag that times
//               the lockout residency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_timer
    import lock_sequencer_pkg::*;
#(
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam int                 C_CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(LOCK_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_count;

    // Load takes priority so the count always starts at zero on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign o_done = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/lock_sequencer.sv
// ============================================================================
// Module      : lock_sequencer
// Description : Password-gated sequencer that steers two confirmed data words
//               into the left and right holding registers, with lockout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_sequencer
    import lock_sequencer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MAX_TRIES   = DEF_MAX_TRIES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [WIDTH-1:0]                 stored_pass,
    input  logic                             request,
    input  logic                             confirm,
    input  logic [WIDTH-1:0]                 pass_data,
    input  logic [WIDTH-1:0]                 din,
    output logic [WIDTH-1:0]                 dout,
    output logic                             en_left,
    output logic                             en_right,
    output logic                             granted,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

    localparam int                 C_TRIES_W = $clog2(MAX_TRIES + 1);
    localparam logic [C_TRIES_W-1:0] C_TRIES_MAX = C_TRIES_W'(MAX_TRIES);
    localparam logic [C_TRIES_W-1:0] C_TRIES_ONE = C_TRIES_W'(1);

    logic [STATE_W-1:0]   r_state;
    logic                 r_confirm_d;
    logic [WIDTH-1:0]     r_pass_q;
    logic [WIDTH-1:0]     r_dout;
    logic                 r_en_left;
    logic                 r_en_right;
    logic [C_TRIES_W-1:0] r_tries;

    logic w_cedge;
    logic w_lock_load;
    logic w_lock_en;
    logic w_lock_done;

    assign w_cedge     = confirm & ~r_confirm_d;
    assign w_lock_load = (r_state == ST_CHECK);
    assign w_lock_en   = (r_state == ST_LOCKOUT);

    lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .clk    (CLK),
        .rst_n  (RST),
        .i_load (w_lock_load),
        .i_en   (w_lock_en),
        .o_done (w_lock_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_confirm_d <= 1'b0;
            r_pass_q    <= '0;
            r_dout      <= '0;
            r_en_left   <= 1'b0;
            r_en_right  <= 1'b0;
            r_tries     <= C_TRIES_MAX;
        end else begin
            r_confirm_d <= confirm;
            r_en_left   <= 1'b0;
            r_en_right  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (request) begin
                        r_state <= ST_GET_PASS;
                    end
                end
                // A dropped request outranks a simultaneous confirm edge.
                ST_GET_PASS: begin
                    if (!request) begin
                        r_state <= ST_IDLE;
                    end else if (w_cedge) begin
                        r_pass_q <= pass_data;
                        r_state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (r_pass_q == stored_pass) begin
                        r_tries <= C_TRIES_MAX;
                        r_state <= ST_LOAD_L;
                    end else if (r_tries > C_TRIES_ONE) begin
                        r_tries <= r_tries - C_TRIES_ONE;
                        r_state <= ST_GET_PASS;
                    end else begin
                        r_tries <= '0;
                        r_state <= ST_LOCKOUT;
                    end
                end
                ST_LOAD_L: begin
                    if (!request) begin
                        r_state <= ST_IDLE;
                    end else if (w_cedge) begin
                        r_dout    <= din;
                        r_en_left <= 1'b1;
                        r_state   <= ST_LOAD_R;
                    end
                end
                ST_LOAD_R: begin
                    if (!request) begin
                        r_state <= ST_IDLE;
                    end else if (w_cedge) begin
                        r_dout     <= din;
                        r_en_right <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_lock_done) begin
                        r_tries <= C_TRIES_MAX;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign en_left    = r_en_left;
    assign en_right   = r_en_right;
    assign granted    = (r_state == ST_LOAD_L) || (r_state == ST_LOAD_R);
    assign locked     = (r_state == ST_LOCKOUT);
    assign tries_left = r_tries;

endmodule

`default_nettype wire

// File: tb/tb_lock_sequencer.sv
// ============================================================================
// Module      : tb_lock_sequencer
// Description : Scoreboard bench for lock_sequencer; expected load pulses are
//               queued by the stimulus and retired by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_sequencer;

    typedef struct {
        bit         is_left;
        logic [3:0] data;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] stored_pass = 4'hA;
    logic       request = 1'b0;
    logic       confirm = 1'b0;
    logic [3:0] pass_data = 4'h0;
    logic [3:0] din = 4'h0;
    logic [3:0] dout;
    logic       en_left;
    logic       en_right;
    logic       granted;
    logic       locked;
    logic [1:0] tries_left;

    exp_t       r_exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] r_left_reg  = 4'h0;
    logic [3:0] r_right_reg = 4'h0;

    lock_sequencer #(
        .WIDTH       (4),
        .MAX_TRIES   (3),
        .LOCK_CYCLES (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .stored_pass (stored_pass),
        .request     (request),
        .confirm     (confirm),
        .pass_data   (pass_data),
        .din         (din),
        .dout        (dout),
        .en_left     (en_left),
        .en_right    (en_right),
        .granted     (granted),
        .locked      (locked),
        .tries_left  (tries_left)
    );

    always #5 CLK = ~CLK;

    // Downstream holding registers as the real system would wire them.
    always @(posedge CLK) begin
        if (en_left)  r_left_reg  <= dout;
        if (en_right) r_right_reg <= dout;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Monitor: every enable pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (RST && (en_left || en_right)) begin
            exp_t e;
            checks++;
            if (en_left && en_right) begin
                errors++;
                $display("FAIL both_enables: en_left=%0b en_right=%0b expected one", en_left, en_right);
            end else if (r_exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_enable: en_left=%0b en_right=%0b dout=%0h expected none",
                         en_left, en_right, dout);
            end else begin
                e = r_exp_q.pop_front();
                if (e.is_left != en_left || e.data != dout) begin
                    errors++;
                    $display("FAIL load_pulse: en_left=%0b dout=%0h expected en_left=%0b dout=%0h",
                             en_left, dout, e.is_left, e.data);
                end
            end
        end
    end

    task automatic attempt(input logic [3:0] p);
        pass_data = p;
        confirm   = 1'b1;
        step(1);
        confirm   = 1'b0;
        step(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lock_cnt;

        // Reset values
        step(3);
        chk("rst_granted", granted, 0);
        chk("rst_locked", locked, 0);
        chk("rst_tries", tries_left, 3);
        chk("rst_dout", dout, 0);
        chk("rst_enables", {en_left, en_right}, 0);
        RST = 1'b1;
        step(1);

        // Grant with the correct password
        request = 1'b1;
        step(1);
        attempt(4'hA);
        chk("grant_granted", granted, 1);
        chk("grant_tries", tries_left, 3);

        // Two data words steered left then right
        din = 4'h5; confirm = 1'b1; r_exp_q.push_back('{1'b1, 4'h5});
        step(1);
        confirm = 1'b0;
        step(1);
        din = 4'h9; confirm = 1'b1; r_exp_q.push_back('{1'b0, 4'h9});
        step(1);
        confirm = 1'b0;
        step(1);
        chk("seq_granted_after", granted, 0);
        chk("seq_left_reg", r_left_reg, 4'h5);
        chk("seq_right_reg", r_right_reg, 4'h9);

        // Three wrong passwords lead to lockout
        step(1);
        attempt(4'h3);
        chk("wrong1_tries", tries_left, 2);
        attempt(4'h4);
        chk("wrong2_tries", tries_left, 1);
        attempt(4'h7);
        chk("wrong3_tries", tries_left, 0);
        chk("wrong3_locked", locked, 1);

        // Lockout lasts 16 cycles no matter what the inputs do
        lock_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            confirm = ~confirm;
            request = (i % 3) != 0;
            pass_data = 4'hA;
            step(1);
            if (!locked) break;
            lock_cnt++;
        end
        request = 1'b0;
        confirm = 1'b0;
        chk("lockout_cycles", lock_cnt, 16);
        chk("lockout_end_tries", tries_left, 3);
        chk("lockout_end_granted", granted, 0);
        step(2);

        // One wrong try, then correct: tries reload on grant
        request = 1'b1;
        step(1);
        attempt(4'h1);
        chk("retry_tries", tries_left, 2);
        attempt(4'hA);
        chk("retry_granted", granted, 1);
        chk("retry_tries_reload", tries_left, 3);

        // Confirm held for 10 cycles yields a single left pulse
        din = 4'h6; confirm = 1'b1; r_exp_q.push_back('{1'b1, 4'h6});
        step(10);
        confirm = 1'b0;
        chk("held_granted", granted, 1);
        step(1);
        din = 4'hC; confirm = 1'b1; r_exp_q.push_back('{1'b0, 4'hC});
        step(1);
        confirm = 1'b0;
        step(1);
        chk("held_left_reg", r_left_reg, 4'h6);
        chk("held_right_reg", r_right_reg, 4'hC);
        chk("held_idle", granted, 0);

        // Abort and confirm edge in the same cycle inside LOAD_L
        step(1);
        attempt(4'hA);
        chk("abort_pre_granted", granted, 1);
        din = 4'hF; confirm = 1'b1; request = 1'b0;
        step(1);
        chk("abort_granted", granted, 0);
        chk("abort_dout", dout, 4'hC);
        confirm = 1'b0;
        step(2);
        chk("abort_dout_hold", dout, 4'hC);
        chk("abort_queue", r_exp_q.size(), 0);

        // Reset in the middle of lockout
        request = 1'b1;
        step(1);
        attempt(4'h3);
        attempt(4'h4);
        attempt(4'h7);
        chk("rlock_locked", locked, 1);
        step(4);
        RST = 1'b0;
        #1;
        chk("rlock_locked_after", locked, 0);
        chk("rlock_tries", tries_left, 3);
        chk("rlock_enables", {en_left, en_right}, 0);
        chk("rlock_granted", granted, 0);
        request = 1'b0;
        step(2);
        RST = 1'b1;
        step(2);
        chk("rlock_idle_locked", locked, 0);

        chk("final_queue_empty", r_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
